dmem_responder: RTL and testbench

- Multi-cycle data-memory responder. It answers load/store requests issued by the memory stage over a valid/ready request and response-pulse interface.
- It is the target-side counterpart of the memory stage's data access. It replaces the zero-latency data memory so the pipeline can be exercised against a memory with a fixed, configurable latency.
- It returns load data, flags bad addresses, and drives a busy indication that pipeline hazard logic uses to hold the memory stage.

---
 rtl/dmem_responder.sv | 106 ++++++++++
 tb/tb_dmem_responder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one load/store at a time over
// valid/ready and returns a single-cycle response after LATENCY cycles.
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);
    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic        accept, enter_resp;
    logic        c_write, c_err;
    logic [31:0] c_addr, c_wdata;
    logic [AW-1:0] c_idx;

    assign req_ready  = (state_q != WAIT);
    assign busy       = (state_q == WAIT);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign accept     = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                    cnt_d   = CNT_INIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign enter_resp = (state_d == RESP) && !reset;

    // With LATENCY=1 the commit happens on the accept edge itself, so the
    // request has to come straight from the inputs rather than the capture regs.
    assign c_write = (LATENCY == 1) ? req_write : wr_q;
    assign c_addr  = (LATENCY == 1) ? req_addr  : addr_q;
    assign c_wdata = (LATENCY == 1) ? req_wdata : wdata_q;
    assign c_idx   = c_addr[AW+1:2];
    assign c_err   = (c_addr[1:0] != 2'b00) || (c_addr[31:AW+2] != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (enter_resp) begin
                err_q   <= c_err;
                rdata_q <= (c_write || c_err) ? 32'd0 : mem_q[c_idx];
            end else begin
                err_q   <= 1'b0;
                rdata_q <= 32'd0;
            end
        end
    end

    // Array is deliberately left out of reset; committed stores survive it.
    always_ff @(posedge clk) begin
        if (enter_resp && c_write && !c_err)
            mem_q[c_idx] <= c_wdata;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: three responders (LATENCY 2, 1, 4) driven with hand-checked vectors.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset     [3];
    logic        req_valid [3];
    logic        req_write [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic        req_ready [3];
    logic        resp_valid[3];
    logic [31:0] resp_rdata[3];
    logic        resp_err  [3];
    logic        busy      [3];
    int          n_chk  = 0;
    int          n_pass = 0;

    localparam int LAT [3] = '{2, 1, 4};

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
        .busy(busy[0]));
    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
        .busy(busy[1]));
    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(4)) u_l4 (
        .clk(clk), .reset(reset[2]), .req_valid(req_valid[2]), .req_write(req_write[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_ready(req_ready[2]),
        .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]),
        .busy(busy[2]));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic chk_idle(input int d, input string tag);
        chk({tag, " valid"}, 32'(resp_valid[d]), 0);
        chk({tag, " rdata"}, resp_rdata[d], 0);
        chk({tag, " err"},   32'(resp_err[d]), 0);
        chk({tag, " ready"}, 32'(req_ready[d]), 1);
        chk({tag, " busy"},  32'(busy[d]), 0);
    endtask

    // Starts at a negedge, ends at the negedge of the response cycle.
    task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input string tag);
        req_valid[d] = 1'b1; req_write[d] = w; req_addr[d] = a; req_wdata[d] = wd;
        chk({tag, " ready@req"}, 32'(req_ready[d]), 1);
        @(posedge clk); #1;
        req_valid[d] = 1'b0; req_addr[d] = 32'hFFFF_FFFF; req_wdata[d] = 32'h0BAD_0BAD;
        for (int k = 1; k < LAT[d]; k++) begin
            @(negedge clk);
            chk({tag, " wait valid"}, 32'(resp_valid[d]), 0);
            chk({tag, " wait ready"}, 32'(req_ready[d]), 0);
            chk({tag, " wait busy"},  32'(busy[d]), 1);
            @(posedge clk);
        end
        @(negedge clk);
        chk({tag, " resp valid"}, 32'(resp_valid[d]), 1);
        chk({tag, " resp rdata"}, resp_rdata[d], exp_rd);
        chk({tag, " resp err"},   32'(resp_err[d]), 32'(exp_err));
        chk({tag, " resp busy"},  32'(busy[d]), 0);
    endtask

    task automatic gap(input int d, input string tag);
        @(posedge clk); @(negedge clk);
        chk_idle(d, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            reset[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0;
            req_addr[d] = '0; req_wdata[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) reset[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk_idle(d, "reset");

        // LATENCY=2
        xact(0, 1, 32'h10, 32'hDEADBEEF, 32'h0, 0, "l2 st 10");
        gap(0, "l2 gap1");
        xact(0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, "l2 ld 10");
        gap(0, "l2 gap2");
        xact(0, 1, 32'h10, 32'hCAFEF00D, 32'h0, 0, "l2 st 10 b2b");
        xact(0, 0, 32'h10, 32'h0, 32'hCAFEF00D, 0, "l2 ld 10 b2b");
        gap(0, "l2 gap3");
        xact(0, 0, 32'h6, 32'h0, 32'h0, 1, "l2 ld misalign");
        gap(0, "l2 gap4");
        xact(0, 1, 32'h12, 32'h1234, 32'h0, 1, "l2 st misalign");
        gap(0, "l2 gap5");
        xact(0, 0, 32'h10, 32'h0, 32'hCAFEF00D, 0, "l2 ld 10 intact");
        gap(0, "l2 gap6");
        xact(0, 1, 32'hFC, 32'h600DF00D, 32'h0, 0, "l2 st word63");
        gap(0, "l2 gap7");
        xact(0, 1, 32'h100, 32'h77777777, 32'h0, 1, "l2 st word64");
        gap(0, "l2 gap8");
        xact(0, 0, 32'hFC, 32'h0, 32'h600DF00D, 0, "l2 ld word63");
        gap(0, "l2 gap9");
        xact(0, 0, 32'h8000_0010, 32'h0, 32'h0, 1, "l2 ld high bit");
        gap(0, "l2 gap10");

        // LATENCY=1: seed four words, then stream four loads
        for (int i = 0; i < 4; i++)
            xact(1, 1, 32'(4 * i), 32'hA000_0000 + 32'(i), 32'h0, 0, "l1 seed");
        gap(1, "l1 gap");
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i < 3) req_addr[1] = 32'(4 * (i + 1));
            else       req_valid[1] = 1'b0;
            @(negedge clk);
            chk("l1 stream valid", 32'(resp_valid[1]), 1);
            chk("l1 stream rdata", resp_rdata[1], 32'hA000_0000 + 32'(i));
            chk("l1 stream ready", 32'(req_ready[1]), 1);
            chk("l1 stream busy",  32'(busy[1]), 0);
        end
        gap(1, "l1 end");

        // LATENCY=4: reset during WAIT drops the store
        xact(2, 1, 32'h20, 32'h11111111, 32'h0, 0, "l4 st pre");
        gap(2, "l4 gap1");
        req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = 32'h20; req_wdata[2] = 32'h55;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        @(negedge clk);
        chk("l4 accepted busy", 32'(busy[2]), 1);
        reset[2] = 1'b1;
        @(posedge clk); #1;
        reset[2] = 1'b0;
        @(negedge clk);
        chk_idle(2, "l4 after reset");
        for (int k = 0; k < 4; k++) gap(2, "l4 no resp");
        xact(2, 0, 32'h20, 32'h0, 32'h11111111, 0, "l4 ld pre value");
        gap(2, "l4 gap2");

        // reset and req_valid together: request must not be taken
        reset[2] = 1'b1; req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = 32'h20;
        req_wdata[2] = 32'h99;
        @(posedge clk); #1;
        reset[2] = 1'b0; req_valid[2] = 1'b0;
        @(negedge clk);
        chk_idle(2, "l4 rst+req");
        for (int k = 0; k < 4; k++) gap(2, "l4 rst+req quiet");
        xact(2, 0, 32'h20, 32'h0, 32'h11111111, 0, "l4 ld after rst+req");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
